link_sweep_ctrl: RTL and testbench
==================================

Name: link_sweep_ctrl

Overview:
- Sequences the emulated serial link through a 2-D sweep of TX FFE and RX CTLE settings, one grid point at a time.
- For each grid point it:
  - drives the settings onto the link and pulses the link reset;
  - waits a settle interval while the CDR locks;
  - counts checker errors over a fixed window of received bits.
- Reports every point and keeps the best (lowest-error) point. On completion it leaves the link running at the best point.
- Sits in the clk_sys domain and replaces static VIO/external control of rst, rx_setting and tx_setting.

Parameters:
- TX_W, 4, width of tx_setting.
- RX_W, 4, width of rx_setting.
- TX_MAX, 15, last TX setting swept (sweep covers 0..TX_MAX).
- RX_MAX, 15, last RX setting swept (sweep covers 0..RX_MAX).
- RST_CYCLES, 16, clk cycles link_rst is held high per point; must be ≥1.
- SETTLE_CYCLES, 4096, clk cycles waited after link_rst deasserts; must be ≥1.
- WINDOW_BITS, 65536, bit_valid strobes counted per measurement; must be ≥1.
- TIMEOUT_CYCLES, 1024, maximum clk gap between bit_valid strobes during a measurement.
- ERR_W, 24, error counter width.

Ports:
- clk, in, 1, system clock (clk_sys).
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, begin a sweep; sampled only in IDLE or DONE.
- abort, in, 1, stop the sweep and return to IDLE.
- bit_valid, in, 1, one-cycle strobe per recovered bit (clk domain).
- bit_err, in, 1, error flag for that bit; qualified by bit_valid.
- link_rst, out, 1, active-high reset to the link.
- tx_setting, out, TX_W, TX setting applied to the link.
- rx_setting, out, RX_W, RX setting applied to the link.
- busy, out, 1, high in every state except IDLE and DONE.
- done, out, 1, high in DONE.
- pt_valid, out, 1, one-cycle strobe when a grid point finishes.
- pt_tx, out, TX_W, setting of the reported point.
- pt_rx, out, RX_W, setting of the reported point.
- pt_err, out, ERR_W, error count of the reported point.
- pt_timeout, out, 1, reported point ended by timeout.
- best_tx, out, TX_W, best point found so far.
- best_rx, out, RX_W, best point found so far.
- best_err, out, ERR_W, error count of the best point.

Behaviour:

Reset (rst low, async):
- State IDLE.
- link_rst=1, all settings 0, busy=0, done=0, pt_valid=0, pt_*=0, best_tx/rx=0, best_err=all-ones.

States and transitions:
- IDLE:
  - link_rst=1.
  - start → APPLY with tx=rx=0; best_err reloads all-ones and best_tx/rx reload 0.
- APPLY:
  - link_rst=1 for exactly RST_CYCLES cycles, then → SETTLE.
  - tx_setting/rx_setting hold the current point for the whole point.
- SETTLE:
  - link_rst=0.
  - Counts SETTLE_CYCLES cycles, then → MEASURE.
  - bit_valid is ignored.
- MEASURE:
  - On each cycle with bit_valid=1:
    - bits++;
    - if bit_err=1, err++, saturating at 2^ERR_W-1.
  - After WINDOW_BITS strobes have been counted → REPORT. The count includes the strobe on the final cycle.
  - A gap counter clears on each bit_valid. If it reaches TIMEOUT_CYCLES → REPORT with err forced to all-ones and pt_timeout=1.
- REPORT (1 cycle):
  - pt_valid=1; pt_tx/pt_rx/pt_err/pt_timeout are registered together with pt_valid and hold until the next report.
  - If err < best_err (strict), best_* ← point. Ties keep the earlier point.
  - Then → NEXT.
- NEXT (1 cycle):
  - If rx<RX_MAX: rx++.
  - Else if tx<TX_MAX: rx←0, tx++.
  - Else → FINAL.
  - Otherwise → APPLY.
- FINAL:
  - tx/rx ← best_tx/best_rx.
  - link_rst=1 for RST_CYCLES cycles, then → DONE.
- DONE:
  - link_rst=0 and the link runs at the best point.
  - done=1 and best_* hold.
  - start → new sweep, as from IDLE.

abort and start:
- abort in any state → IDLE next cycle: link_rst=1, counters cleared, pt_valid=0.
- best_* and pt_* keep their values after abort.
- abort wins over start in the same cycle.
- start is ignored while busy.

Counters and timing:
- Counters are sized with $clog2 of their limit plus 1, so no wrap inside a phase.
- Error and bit counters clear on entry to MEASURE.
- Point latency = RST_CYCLES + SETTLE_CYCLES + measurement time + 2 cycles (REPORT, NEXT).

Test Plan:
- Nominal sweep, TX_MAX=RX_MAX=1, RST_CYCLES=2, SETTLE=4, WINDOW=8, bit_valid every cycle, bit_err only at point (1,0) → pt_valid 4 times in order (0,0),(0,1),(1,0),(1,1) with pt_err 0,0,8,0; best=(0,0); DONE with tx=rx=0 and link_rst=0.
- Ties and strict improvement, errors per point 5,3,3,7 → best=(0,1), best_err=3.
- Timeout: bit_valid stops mid-window at point (0,1) → after TIMEOUT_CYCLES, pt_timeout=1 and pt_err=all-ones; the sweep continues to (1,0).
- Saturation: ERR_W=3, WINDOW=16, all bits in error → pt_err=7.
- Abort during SETTLE of point (1,0) → next cycle IDLE, link_rst=1, busy=0; best_* equal the best of the first two points.
- Async reset asserted mid-MEASURE (not clock-aligned) → outputs return to reset values immediately; start after reset release runs a full sweep from (0,0); start pulses during busy have no effect.

Source files
------------

// File: rtl/link_sweep_ctrl.sv
// Link tuning sequencer: walks a TX FFE x RX CTLE grid, measures the bit error count at each
// point, reports every point and parks the link at the lowest-error setting when finished.
module link_sweep_ctrl #(
  parameter int unsigned TX_W           = 4,
  parameter int unsigned RX_W           = 4,
  parameter int unsigned TX_MAX         = 15,
  parameter int unsigned RX_MAX         = 15,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 4096,
  parameter int unsigned WINDOW_BITS    = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ERR_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_err,
  output logic             link_rst,
  output logic [TX_W-1:0]  tx_setting,
  output logic [RX_W-1:0]  rx_setting,
  output logic             busy,
  output logic             done,
  output logic             pt_valid,
  output logic [TX_W-1:0]  pt_tx,
  output logic [RX_W-1:0]  pt_rx,
  output logic [ERR_W-1:0] pt_err,
  output logic             pt_timeout,
  output logic [TX_W-1:0]  best_tx,
  output logic [RX_W-1:0]  best_rx,
  output logic [ERR_W-1:0] best_err
);

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StMeasure,
    StReport,
    StNext,
    StFinal,
    StDone
  } state_e;

  // One phase counter serves APPLY, SETTLE and FINAL, so it is sized for the longer interval.
  localparam int unsigned PhaseMax = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax) + 1;
  localparam int unsigned BitW     = $clog2(WINDOW_BITS) + 1;
  localparam int unsigned GapW     = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PhaseW-1:0] RstLast    = PhaseW'(RST_CYCLES - 1);
  localparam logic [PhaseW-1:0] SettleLast = PhaseW'(SETTLE_CYCLES - 1);
  localparam logic [BitW-1:0]   WinLast    = BitW'(WINDOW_BITS - 1);
  localparam logic [GapW-1:0]   GapLast    = GapW'(TIMEOUT_CYCLES - 1);
  localparam logic [TX_W-1:0]   TxLast     = TX_W'(TX_MAX);
  localparam logic [RX_W-1:0]   RxLast     = RX_W'(RX_MAX);
  localparam logic [ERR_W-1:0]  ErrMax     = '1;

  state_e             state_q, state_d;
  logic [PhaseW-1:0]  phase_q, phase_d;
  logic [BitW-1:0]    bits_q, bits_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [TX_W-1:0]    tx_q, tx_d;
  logic [RX_W-1:0]    rx_q, rx_d;
  logic               link_rst_q, link_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pt_valid_q, pt_valid_d;
  logic [TX_W-1:0]    pt_tx_q, pt_tx_d;
  logic [RX_W-1:0]    pt_rx_q, pt_rx_d;
  logic [ERR_W-1:0]   pt_err_q, pt_err_d;
  logic               pt_timeout_q, pt_timeout_d;
  logic [TX_W-1:0]    best_tx_q, best_tx_d;
  logic [RX_W-1:0]    best_rx_q, best_rx_d;
  logic [ERR_W-1:0]   best_err_q, best_err_d;
  logic               meas_timeout;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bits_d       = bits_q;
    gap_d        = gap_q;
    err_d        = err_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    pt_tx_d      = pt_tx_q;
    pt_rx_d      = pt_rx_q;
    pt_err_d     = pt_err_q;
    pt_timeout_d = pt_timeout_q;
    best_tx_d    = best_tx_q;
    best_rx_d    = best_rx_q;
    best_err_d   = best_err_q;
    meas_timeout = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StApply;
          phase_d    = '0;
          tx_d       = '0;
          rx_d       = '0;
          best_tx_d  = '0;
          best_rx_d  = '0;
          best_err_d = ErrMax;
        end
      end
      StApply: begin
        if (phase_q == RstLast) begin
          state_d = StSettle;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StSettle: begin
        if (phase_q == SettleLast) begin
          state_d = StMeasure;
          phase_d = '0;
          bits_d  = '0;
          gap_d   = '0;
          err_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StMeasure: begin
        if (bit_valid) begin
          gap_d  = '0;
          bits_d = bits_q + 1'b1;
          if (bit_err && (err_q != ErrMax)) begin
            err_d = err_q + 1'b1;
          end
          if (bits_q == WinLast) begin
            state_d = StReport;
          end
        end else if (gap_q == GapLast) begin
          // A stalled bit stream scores worst so it can never become the best point.
          state_d      = StReport;
          err_d        = ErrMax;
          meas_timeout = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StReport: begin
        if (err_q < best_err_q) begin
          best_tx_d  = tx_q;
          best_rx_d  = rx_q;
          best_err_d = err_q;
        end
        state_d = StNext;
      end
      StNext: begin
        phase_d = '0;
        if (rx_q < RxLast) begin
          rx_d    = rx_q + 1'b1;
          state_d = StApply;
        end else if (tx_q < TxLast) begin
          rx_d    = '0;
          tx_d    = tx_q + 1'b1;
          state_d = StApply;
        end else begin
          tx_d    = best_tx_q;
          rx_d    = best_rx_q;
          state_d = StFinal;
        end
      end
      StFinal: begin
        if (phase_q == RstLast) begin
          state_d = StDone;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      phase_d = '0;
      bits_d  = '0;
      gap_d   = '0;
      err_d   = '0;
    end

    // Point results are latched on the same edge that raises pt_valid.
    if ((state_q == StMeasure) && (state_d == StReport)) begin
      pt_tx_d      = tx_q;
      pt_rx_d      = rx_q;
      pt_err_d     = err_d;
      pt_timeout_d = meas_timeout;
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    link_rst_d = (state_d == StIdle) || (state_d == StApply) || (state_d == StFinal);
    busy_d     = !((state_d == StIdle) || (state_d == StDone));
    done_d     = (state_d == StDone);
    pt_valid_d = (state_d == StReport);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      bits_q       <= '0;
      gap_q        <= '0;
      err_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      link_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pt_valid_q   <= 1'b0;
      pt_tx_q      <= '0;
      pt_rx_q      <= '0;
      pt_err_q     <= '0;
      pt_timeout_q <= 1'b0;
      best_tx_q    <= '0;
      best_rx_q    <= '0;
      best_err_q   <= ErrMax;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bits_q       <= bits_d;
      gap_q        <= gap_d;
      err_q        <= err_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      link_rst_q   <= link_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pt_valid_q   <= pt_valid_d;
      pt_tx_q      <= pt_tx_d;
      pt_rx_q      <= pt_rx_d;
      pt_err_q     <= pt_err_d;
      pt_timeout_q <= pt_timeout_d;
      best_tx_q    <= best_tx_d;
      best_rx_q    <= best_rx_d;
      best_err_q   <= best_err_d;
    end
  end

  assign link_rst   = link_rst_q;
  assign tx_setting = tx_q;
  assign rx_setting = rx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pt_valid   = pt_valid_q;
  assign pt_tx      = pt_tx_q;
  assign pt_rx      = pt_rx_q;
  assign pt_err     = pt_err_q;
  assign pt_timeout = pt_timeout_q;
  assign best_tx    = best_tx_q;
  assign best_rx    = best_rx_q;
  assign best_err   = best_err_q;

endmodule

// File: tb/tb_link_sweep_ctrl.sv
// Self-checking bench for link_sweep_ctrl: planned and random per-point bit streams are scored
// by a behavioural model (error tally, best-point search, latency arithmetic) kept in the bench.
module tb_link_sweep_ctrl;

  localparam int unsigned TxW       = 4;
  localparam int unsigned RxW       = 4;
  localparam int unsigned TxMax     = 1;
  localparam int unsigned RxMax     = 1;
  localparam int unsigned RstCyc    = 2;
  localparam int unsigned SettleCyc = 4;
  localparam int unsigned Window    = 8;
  localparam int unsigned Timeout   = 10;
  localparam int unsigned ErrW      = 8;
  localparam int unsigned NPts      = (TxMax + 1) * (RxMax + 1);
  localparam int          ErrAll    = (1 << ErrW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_err = 1'b0;
  logic            link_rst, busy, done, pt_valid, pt_timeout;
  logic [TxW-1:0]  tx_setting, pt_tx, best_tx;
  logic [RxW-1:0]  rx_setting, pt_rx, best_rx;
  logic [ErrW-1:0] pt_err, best_err;

  link_sweep_ctrl #(
    .TX_W(TxW), .RX_W(RxW), .TX_MAX(TxMax), .RX_MAX(RxMax), .RST_CYCLES(RstCyc),
    .SETTLE_CYCLES(SettleCyc), .WINDOW_BITS(Window), .TIMEOUT_CYCLES(Timeout), .ERR_W(ErrW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_valid(bit_valid),
    .bit_err(bit_err), .link_rst(link_rst), .tx_setting(tx_setting), .rx_setting(rx_setting),
    .busy(busy), .done(done), .pt_valid(pt_valid), .pt_tx(pt_tx), .pt_rx(pt_rx),
    .pt_err(pt_err), .pt_timeout(pt_timeout), .best_tx(best_tx), .best_rx(best_rx),
    .best_err(best_err)
  );

  // Single-point instance with a 3-bit error counter and every bit in error.
  logic       s_start = 1'b0;
  logic       s_link_rst, s_busy, s_done, s_pt_valid, s_pt_timeout;
  logic [3:0] s_tx, s_rx, s_pt_tx, s_pt_rx, s_best_tx, s_best_rx;
  logic [2:0] s_pt_err, s_best_err;

  link_sweep_ctrl #(
    .TX_W(4), .RX_W(4), .TX_MAX(0), .RX_MAX(0), .RST_CYCLES(2), .SETTLE_CYCLES(4),
    .WINDOW_BITS(16), .TIMEOUT_CYCLES(10), .ERR_W(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .bit_valid(1'b1), .bit_err(1'b1),
    .link_rst(s_link_rst), .tx_setting(s_tx), .rx_setting(s_rx), .busy(s_busy), .done(s_done),
    .pt_valid(s_pt_valid), .pt_tx(s_pt_tx), .pt_rx(s_pt_rx), .pt_err(s_pt_err),
    .pt_timeout(s_pt_timeout), .best_tx(s_best_tx), .best_rx(s_best_rx), .best_err(s_best_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int best_err_m, best_tx_m, best_rx_m;
  int last_tx_m, last_rx_m, last_err_m, last_to_m;
  int plan_err[NPts];   // leading strobes in error, -1 for random errors
  int plan_stop[NPts];  // strobe count after which bit_valid stops, -1 for never
  bit plan_rand;        // random bit_valid spacing instead of back-to-back

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bit_valid = ($urandom_range(1, 0) == 1);
    bit_err   = ($urandom_range(1, 0) == 1);
    start     = ($urandom_range(3, 0) == 0);
    abort     = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_link_rst"}, 32'(link_rst), 1);
    check_eq({pfx, "_tx"}, 32'(tx_setting), 0);
    check_eq({pfx, "_rx"}, 32'(rx_setting), 0);
    check_eq({pfx, "_busy"}, 32'(busy), 0);
    check_eq({pfx, "_done"}, 32'(done), 0);
    check_eq({pfx, "_pt_valid"}, 32'(pt_valid), 0);
    check_eq({pfx, "_pt_tx"}, 32'(pt_tx), 0);
    check_eq({pfx, "_pt_rx"}, 32'(pt_rx), 0);
    check_eq({pfx, "_pt_err"}, 32'(pt_err), 0);
    check_eq({pfx, "_pt_timeout"}, 32'(pt_timeout), 0);
    check_eq({pfx, "_best_tx"}, 32'(best_tx), 0);
    check_eq({pfx, "_best_rx"}, 32'(best_rx), 0);
    check_eq({pfx, "_best_err"}, 32'(best_err), ErrAll);
  endtask

  task automatic model_reset();
    best_err_m = ErrAll; best_tx_m = 0; best_rx_m = 0;
    last_tx_m = 0; last_rx_m = 0; last_err_m = 0; last_to_m = 0;
  endtask

  // cut_kind: 0 full sweep, 1 abort in SETTLE of point cut_pt, 2 async reset in its MEASURE.
  task automatic run_sweep(input int cut_pt, input int cut_kind);
    best_err_m = ErrAll; best_tx_m = 0; best_rx_m = 0;
    start = 1'b1; abort = 1'b0; bit_valid = 1'b0; bit_err = 1'b0;
    step();
    start = 1'b0;
    for (int p = 0; p < NPts; p++) begin
      int tx, rx, strobes, errs, gap, cyc, hold, exp_err;
      bit fin, to, v, e;
      tx = p / (RxMax + 1);
      rx = p % (RxMax + 1);
      for (int k = 0; k < RstCyc; k++) begin
        check_eq("apply_link_rst", 32'(link_rst), 1);
        check_eq("apply_tx", 32'(tx_setting), tx);
        check_eq("apply_rx", 32'(rx_setting), rx);
        check_eq("apply_busy", 32'(busy), 1);
        noise();
        step();
      end
      for (int k = 0; k < SettleCyc; k++) begin
        check_eq("settle_link_rst", 32'(link_rst), 0);
        check_eq("settle_tx", 32'(tx_setting), tx);
        check_eq("settle_rx", 32'(rx_setting), rx);
        if (cut_kind == 1 && p == cut_pt && k == 1) begin
          abort = 1'b1; start = 1'b1; bit_valid = 1'b0;
          step();
          abort = 1'b0; start = 1'b0;
          check_eq("abort_link_rst", 32'(link_rst), 1);
          check_eq("abort_busy", 32'(busy), 0);
          check_eq("abort_done", 32'(done), 0);
          check_eq("abort_pt_valid", 32'(pt_valid), 0);
          check_eq("abort_best_tx", 32'(best_tx), best_tx_m);
          check_eq("abort_best_rx", 32'(best_rx), best_rx_m);
          check_eq("abort_best_err", 32'(best_err), best_err_m);
          check_eq("abort_pt_tx", 32'(pt_tx), last_tx_m);
          check_eq("abort_pt_rx", 32'(pt_rx), last_rx_m);
          check_eq("abort_pt_err", 32'(pt_err), last_err_m);
          step();
          check_eq("abort_stays_idle", 32'(busy), 0);
          check_eq("abort_idle_link_rst", 32'(link_rst), 1);
          return;
        end
        noise();
        step();
      end
      strobes = 0; errs = 0; gap = 0; cyc = 0; hold = 0; fin = 1'b0; to = 1'b0;
      while (!fin) begin
        check_eq("meas_pt_valid", 32'(pt_valid), 0);
        check_eq("meas_link_rst", 32'(link_rst), 0);
        if (plan_stop[p] >= 0 && strobes >= plan_stop[p]) begin
          v = 1'b0;
        end else if (!plan_rand) begin
          v = 1'b1;
        end else if (hold > 1) begin
          v = 1'b0; hold--;
        end else if (hold == 1) begin
          v = 1'b1; hold = 0;
        end else begin
          v = ($urandom_range(9, 0) < 6);
          // Occasionally a gap one cycle short of the timeout.
          if (!v && gap == 0 && $urandom_range(5, 0) == 0) hold = Timeout - 1;
        end
        if (v && plan_err[p] >= 0) e = (strobes < plan_err[p]);
        else e = ($urandom_range(1, 0) == 1);
        bit_valid = v; bit_err = e; start = ($urandom_range(3, 0) == 0);
        step();
        cyc++;
        if (v) begin
          strobes++; gap = 0;
          if (e) errs++;
          if (strobes == Window) fin = 1'b1;
        end else begin
          gap++;
          if (gap == Timeout) begin fin = 1'b1; to = 1'b1; end
        end
        if (cut_kind == 2 && p == cut_pt && cyc == 3 && !fin) begin
          #2 rst = 1'b0;
          #1 check_reset_vals("areset");
          model_reset();
          bit_valid = 1'b0; start = 1'b0;
          #2 rst = 1'b1;
          step();
          check_eq("areset_idle_busy", 32'(busy), 0);
          return;
        end
        if (cyc > 400) begin
          check_eq("meas_budget", 32'(cyc), 0);
          fin = 1'b1;
        end
      end
      exp_err = to ? ErrAll : ((errs > ErrAll) ? ErrAll : errs);
      check_eq("rep_pt_valid", 32'(pt_valid), 1);
      check_eq("rep_pt_tx", 32'(pt_tx), tx);
      check_eq("rep_pt_rx", 32'(pt_rx), rx);
      check_eq("rep_pt_err", 32'(pt_err), exp_err);
      check_eq("rep_pt_timeout", 32'(pt_timeout), 32'(to));
      check_eq("rep_busy", 32'(busy), 1);
      last_tx_m = tx; last_rx_m = rx; last_err_m = exp_err; last_to_m = int'(to);
      if (exp_err < best_err_m) begin
        best_err_m = exp_err; best_tx_m = tx; best_rx_m = rx;
      end
      noise();
      step();
      check_eq("next_pt_valid", 32'(pt_valid), 0);
      check_eq("next_pt_err_hold", 32'(pt_err), last_err_m);
      check_eq("next_best_tx", 32'(best_tx), best_tx_m);
      check_eq("next_best_rx", 32'(best_rx), best_rx_m);
      check_eq("next_best_err", 32'(best_err), best_err_m);
      noise();
      step();
    end
    for (int k = 0; k < RstCyc; k++) begin
      check_eq("final_link_rst", 32'(link_rst), 1);
      check_eq("final_tx", 32'(tx_setting), best_tx_m);
      check_eq("final_rx", 32'(rx_setting), best_rx_m);
      check_eq("final_busy", 32'(busy), 1);
      noise();
      step();
    end
    bit_valid = 1'b0; start = 1'b0;
    check_eq("done_done", 32'(done), 1);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("done_link_rst", 32'(link_rst), 0);
    check_eq("done_tx", 32'(tx_setting), best_tx_m);
    check_eq("done_rx", 32'(rx_setting), best_rx_m);
    check_eq("done_best_err", 32'(best_err), best_err_m);
    check_eq("done_best_tx", 32'(best_tx), best_tx_m);
    check_eq("done_best_rx", 32'(best_rx), best_rx_m);
    step();
    check_eq("done_hold", 32'(done), 1);
    check_eq("done_hold_pt_valid", 32'(pt_valid), 0);
  endtask

  initial begin
    int n;
    model_reset();
    #23;
    check_reset_vals("reset");
    #4 rst = 1'b1;
    step();
    check_eq("idle_link_rst", 32'(link_rst), 1);

    // Saturation: 16 errored bits into a 3-bit counter.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n = 0;
    while (!s_pt_valid && n < 100) begin
      step();
      n++;
    end
    check_eq("sat_latency", 32'(n), 2 + 4 + 16);
    check_eq("sat_pt_err", 32'(s_pt_err), 7);
    check_eq("sat_pt_timeout", 32'(s_pt_timeout), 0);
    step();
    check_eq("sat_best_err", 32'(s_best_err), 7);
    repeat (3) step();
    check_eq("sat_done", 32'(s_done), 1);
    check_eq("sat_link_rst", 32'(s_link_rst), 0);
    check_eq("main_still_idle", 32'(busy), 0);

    plan_rand = 1'b0;
    plan_stop = '{-1, -1, -1, -1};
    plan_err  = '{0, 0, 8, 0};
    run_sweep(-1, 0);
    plan_err  = '{5, 3, 3, 7};
    run_sweep(-1, 0);
    plan_err  = '{1, 2, 0, 4};
    plan_stop = '{-1, 3, -1, -1};
    run_sweep(-1, 0);
    plan_err  = '{4, 2, 1, 1};
    plan_stop = '{-1, -1, -1, -1};
    run_sweep(2, 1);

    plan_rand = 1'b1;
    plan_err  = '{-1, -1, -1, -1};
    run_sweep(1, 2);
    for (int s = 0; s < 5; s++) begin
      for (int p = 0; p < NPts; p++) begin
        plan_stop[p] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(Window - 1, 0)) : -1;
        plan_err[p]  = ($urandom_range(1, 0) == 0) ? int'($urandom_range(Window, 0)) : -1;
      end
      run_sweep(-1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
